// File: rtl/avst_packet_sink.sv
// avst_packet_sink: Avalon-ST packet sink with byte buffer and per-packet status.
// Stores payload bytes at buffer[k] for byte k of a packet and reports length,
// mod-2^16 checksum and framing/overflow errors once the packet completes.
// Optional: define AVST_SINK_BACKPRESSURE_EN to gate in_ready with an LFSR.
module avst_packet_sink #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned EMPTY_W   = 2,
  parameter int unsigned MAX_BYTES = 2048,
  parameter int unsigned ADDR_W    = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_startofpacket,
  input  logic                in_endofpacket,
  input  logic [EMPTY_W-1:0]  in_empty,
  output logic                status_valid,
  input  logic                status_ack,
  output logic [15:0]         status_len,
  output logic [15:0]         status_csum,
  output logic [1:0]          status_err,
  output logic [7:0]          stray_cnt,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [7:0]          rd_data
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(BYTES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0] mem [MAX_BYTES];

  logic [15:0] len_q;
  logic [15:0] csum_q;
  logic [1:0]  err_q;
  logic [15:0] len_nxt;
  logic [15:0] csum_nxt;
  logic [1:0]  err_nxt;

  logic             accept;
  logic             start;
  logic             restart;
  logic             take;
  logic             stop_store;
  logic [CNT_W-1:0] beat_len;
  logic [16:0]      base;
  logic [15:0]      beat_sum;
  logic             beat_ovf;
  logic [BYTES-1:0] we;
  logic [7:0]       wbyte  [BYTES];
  logic [16:0]      byte_k [BYTES];
  logic [ADDR_W-1:0] waddr [BYTES];

`ifdef AVST_SINK_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR (taps 16,14,13,11) that throttles in_ready every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
`endif

  // Beat handshake qualifiers; a sop beat always restarts the byte count at zero
  assign accept     = in_valid && in_ready;
  assign start      = accept && in_startofpacket;
  assign restart    = start && (state == RECV);
  assign take       = accept && (in_startofpacket || (state == RECV));
  assign stop_store = !start && err_q[1];
  assign base       = start ? 17'd0 : {1'b0, len_q};
  assign beat_len   = in_endofpacket ? (CNT_W'(BYTES) - CNT_W'(in_empty)) : CNT_W'(BYTES);

  // Per-byte lane decode: checksum contribution, overflow detection and write enables
  always_comb begin
    beat_sum = 16'd0;
    beat_ovf = 1'b0;
    we       = '0;
    for (int j = 0; j < BYTES; j++) begin
      wbyte[j]  = in_data[DATA_W-1-8*j -: 8];
      byte_k[j] = base + 17'(j);
      waddr[j]  = byte_k[j][ADDR_W-1:0];
      if (CNT_W'(j) < beat_len) begin
        beat_sum = beat_sum + 16'(wbyte[j]);
        if (byte_k[j] >= 17'(MAX_BYTES)) begin
          beat_ovf = 1'b1;
        end else begin
          we[j] = take && !stop_store;
        end
      end
    end
  end

  // Next accumulator values: restart from this beat on sop, otherwise accumulate
  always_comb begin
    if (start) begin
      len_nxt  = 16'(beat_len);
      csum_nxt = beat_sum;
      err_nxt  = {beat_ovf, restart};
    end else begin
      len_nxt  = len_q + 16'(beat_len);
      csum_nxt = csum_q + beat_sum;
      err_nxt  = {err_q[1] | beat_ovf, err_q[0]};
    end
  end

  // Packet accumulators advance only on beats that belong to a packet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q  <= 16'd0;
      csum_q <= 16'd0;
      err_q  <= 2'b00;
    end else if (take) begin
      len_q  <= len_nxt;
      csum_q <= csum_nxt;
      err_q  <= err_nxt;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && in_startofpacket) begin
          state_nxt = in_endofpacket ? DONE : RECV;
        end
      end
      RECV: begin
        if (accept && in_endofpacket) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (status_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state only
  always_comb begin
    status_valid = 1'b0;
    in_ready     = 1'b0;
    case (state)
      IDLE, RECV: begin
`ifdef AVST_SINK_BACKPRESSURE_EN
        in_ready = lfsr[0];
`else
        in_ready = 1'b1;
`endif
      end
      DONE: begin
        status_valid = 1'b1;
      end
      default: begin
        status_valid = 1'b0;
        in_ready     = 1'b0;
      end
    endcase
  end

  // Status snapshot loads on the edge that enters DONE and holds until the next packet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_len  <= 16'd0;
      status_csum <= 16'd0;
      status_err  <= 2'b00;
    end else if ((state != DONE) && (state_nxt == DONE)) begin
      status_len  <= len_nxt;
      status_csum <= csum_nxt;
      status_err  <= err_nxt;
    end
  end

  // Saturating count of beats seen in IDLE without sop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stray_cnt <= 8'd0;
    end else if (accept && (state == IDLE) && !in_startofpacket && (stray_cnt != 8'hFF)) begin
      stray_cnt <= stray_cnt + 8'd1;
    end
  end

  // Byte buffer write; contents survive reset
  always_ff @(posedge clk) begin
    for (int j = 0; j < BYTES; j++) begin
      if (we[j]) begin
        mem[waddr[j]] <= wbyte[j];
      end
    end
  end

  // Registered read port; a same-cycle write returns the previous byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 8'd0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_avst_packet_sink.sv
// Self-checking bench for avst_packet_sink: a full-size instance and a 16-byte
// buffer instance share stimulus; expected status is queued per packet.
module tb_avst_packet_sink;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned EMPTY_W   = 2;
  localparam int unsigned MAX_BYTES = 2048;
  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned SM_BYTES  = 16;
  localparam int unsigned SM_ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_startofpacket;
  logic               in_endofpacket;
  logic [EMPTY_W-1:0] in_empty;
  logic               status_ack;
  logic [ADDR_W-1:0]  rd_addr;
  logic [SM_ADDR_W-1:0] rd_addr_s;

  logic        in_ready, status_valid;
  logic [15:0] status_len, status_csum;
  logic [1:0]  status_err;
  logic [7:0]  stray_cnt, rd_data;

  logic        in_ready_s, status_valid_s;
  logic [15:0] status_len_s, status_csum_s;
  logic [1:0]  status_err_s;
  logic [7:0]  stray_cnt_s, rd_data_s;

  always #5 clk = ~clk;

  avst_packet_sink #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .MAX_BYTES(MAX_BYTES), .ADDR_W(ADDR_W)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket), .in_empty(in_empty),
    .status_valid(status_valid), .status_ack(status_ack), .status_len(status_len),
    .status_csum(status_csum), .status_err(status_err), .stray_cnt(stray_cnt),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  avst_packet_sink #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .MAX_BYTES(SM_BYTES), .ADDR_W(SM_ADDR_W)) u_small (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket), .in_empty(in_empty),
    .status_valid(status_valid_s), .status_ack(status_ack), .status_len(status_len_s),
    .status_csum(status_csum_s), .status_err(status_err_s), .stray_cnt(stray_cnt_s),
    .rd_addr(rd_addr_s), .rd_data(rd_data_s)
  );

  typedef struct {
    logic [15:0] len;
    logic [15:0] csum;
    logic [1:0]  err;
    logic [1:0]  err_s;
  } exp_t;

  typedef logic [7:0] byte_q_t[$];

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  int          m_state = 0;
  int          m_k = 0;
  logic [15:0] m_len, m_csum;
  logic [1:0]  m_err, m_err_s;
  logic [7:0]  m_stray = 8'd0;
  logic [7:0]  mdl_buf [MAX_BYTES];
  logic [7:0]  mdl_sm  [SM_BYTES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_beat(input logic [31:0] d, input logic sop, input logic eop, input logic [1:0] empty);
    int nb;
    logic [7:0] b;
    nb = eop ? (4 - int'(empty)) : 4;
    if (m_state == 0 && !sop) begin
      if (m_stray != 8'hFF) m_stray++;
      return;
    end
    if (sop) begin
      m_err   = (m_state == 1) ? 2'b01 : 2'b00;
      m_err_s = m_err;
      m_len   = 16'd0;
      m_csum  = 16'd0;
      m_k     = 0;
    end
    for (int j = 0; j < nb; j++) begin
      b      = d[31-8*j -: 8];
      m_csum = m_csum + 16'(b);
      m_len  = m_len + 16'd1;
      if (m_k < MAX_BYTES) mdl_buf[m_k] = b; else m_err[1] = 1'b1;
      if (m_k < SM_BYTES)  mdl_sm[m_k]  = b; else m_err_s[1] = 1'b1;
      m_k++;
    end
    if (eop) begin
      exp_q.push_back('{len: m_len, csum: m_csum, err: m_err, err_s: m_err_s});
      m_state = 0;
    end else begin
      m_state = 1;
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop, input logic [1:0] empty);
    int guard;
    @(negedge clk);
    in_data = d; in_valid = 1'b1; in_startofpacket = sop; in_endofpacket = eop; in_empty = empty;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      model_beat(d, sop, eop, empty);
    end
    @(negedge clk);
    in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_empty = '0;
  endtask

  task automatic send_packet(input byte_q_t pkt);
    int n, nbeats, idx;
    logic [31:0] d;
    n = pkt.size();
    nbeats = (n + 3) / 4;
    for (int bt = 0; bt < nbeats; bt++) begin
      d = 32'd0;
      for (int j = 0; j < 4; j++) begin
        idx = bt * 4 + j;
        if (idx < n) d[31-8*j -: 8] = pkt[idx];
      end
      send_beat(d, bt == 0, bt == nbeats - 1, (bt == nbeats - 1) ? 2'(nbeats * 4 - n) : 2'd0);
    end
  endtask

  task automatic check_status(input string tag);
    int guard, nrd;
    exp_t e;
    guard = 0;
    while (!status_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_valid"}, 32'(status_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_len"},    32'(status_len),    32'(e.len));
    check({tag, "_csum"},   32'(status_csum),   32'(e.csum));
    check({tag, "_err"},    32'(status_err),    32'(e.err));
    check({tag, "_len_s"},  32'(status_len_s),  32'(e.len));
    check({tag, "_csum_s"}, 32'(status_csum_s), 32'(e.csum));
    check({tag, "_err_s"},  32'(status_err_s),  32'(e.err_s));
    check({tag, "_ready_done"}, 32'(in_ready), 32'd0);
    nrd = (int'(e.len) < MAX_BYTES) ? int'(e.len) : MAX_BYTES;
    for (int k = 0; k < nrd; k++) begin
      rd_addr   = ADDR_W'(k);
      rd_addr_s = SM_ADDR_W'(k);
      @(negedge clk);
      check($sformatf("%s_rd%0d", tag, k), 32'(rd_data), 32'(mdl_buf[k]));
      if (k < SM_BYTES) check($sformatf("%s_rds%0d", tag, k), 32'(rd_data_s), 32'(mdl_sm[k]));
    end
    status_ack = 1'b1;
    @(negedge clk);
    status_ack = 1'b0;
    check({tag, "_valid_after_ack"}, 32'(status_valid), 32'd0);
    check({tag, "_ready_after_ack"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_state = 0;
    m_stray = 8'd0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t pkt;
    logic [7:0] old_b;
    logic [7:0] held_len;
    int lens [8] = '{20, 20, 20, 20, 16, 17, 1, 11};

    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_startofpacket = 1'b0;
    in_endofpacket = 1'b0; in_empty = '0; status_ack = 1'b0; rd_addr = '0; rd_addr_s = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(status_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_len",   32'(status_len), 32'd0);
    check("rst_csum",  32'(status_csum), 32'd0);
    check("rst_err",   32'(status_err), 32'd0);
    check("rst_stray", 32'(stray_cnt), 32'd0);
    check("rst_rd",    32'(rd_data), 32'd0);
    reset = 1'b0;

    // 20 incrementing bytes; overflows the 16-byte instance
    pkt = {};
    for (int i = 0; i < 20; i++) pkt.push_back(8'(i));
    send_packet(pkt);
    check("inc20_len_const", 32'(status_len), 32'd20);
    check("inc20_csum_const", 32'(status_csum), 32'h00BE);
    check("inc20_errs_const", 32'(status_err_s), 32'd2);
    check_status("inc20");

    // 7 x 0xFF, with a same-cycle read of address 0 returning the old byte
    pkt = {};
    for (int i = 0; i < 7; i++) pkt.push_back(8'hFF);
    rd_addr = '0; rd_addr_s = '0;
    old_b = mdl_buf[0];
    send_beat(32'hFFFF_FFFF, 1'b1, 1'b0, 2'd0);
    check("rw_old_byte", 32'(rd_data), 32'(old_b));
    @(negedge clk);
    check("rw_new_byte", 32'(rd_data), 32'hFF);
    send_beat(32'hFFFF_FF00, 1'b0, 1'b1, 2'd1);
    check("ff7_csum_const", 32'(status_csum), 32'h06F9);
    check_status("ff7");

    // Stray beats in IDLE
    for (int i = 0; i < 3; i++) send_beat(32'hDEAD_0000 + 32'(i), 1'b0, 1'b0, 2'd0);
    check("stray_cnt", 32'(stray_cnt), 32'(m_stray));
    check("stray_cnt_const", 32'(stray_cnt), 32'd3);
    check("stray_novalid", 32'(status_valid), 32'd0);

    // Restart: sop, 2 beats, then sop+eop; hold ack low for 10 cycles
    send_beat(32'hAAAA_AAAA, 1'b1, 1'b0, 2'd0);
    send_beat(32'hBBBB_BBBB, 1'b0, 1'b0, 2'd0);
    send_beat(32'h0102_0304, 1'b1, 1'b1, 2'd0);
    check("restart_err_const", 32'(status_err), 32'd1);
    held_len = status_len[7:0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_ready%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("hold_len%0d", i), 32'(status_len), 32'd4);
    end
    check("hold_len_start", 32'(held_len), 32'd4);
    check_status("restart");

    // Reset mid-packet
    send_beat(32'h1111_1111, 1'b1, 1'b0, 2'd0);
    do_reset();
    check("midrst_valid", 32'(status_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_stray", 32'(stray_cnt), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_stray_after", 32'(stray_cnt), 32'd0);
    check("midrst_valid_after", 32'(status_valid), 32'd0);

    // Random payloads, including the 16/17-byte boundary of the small buffer
    for (int p = 0; p < 8; p++) begin
      pkt = {};
      for (int i = 0; i < lens[p]; i++) pkt.push_back(8'($urandom_range(0, 255)));
      send_packet(pkt);
      check_status($sformatf("rnd%0d", p));
    end
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
